// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register for the MIPS core.
// Holds one control bundle and one datapath bundle with a valid bit.
// The stage supports hazard stall/flush and downstream back-pressure.
// With SKID=1 a one-entry skid buffer lets ready_o be registered.
// Two saturating counters record stall and flush events for debug.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              ready_s;
  logic              skid_valid_s;
  logic              stall_ev_s;
  logic              flush_ev_s;

  // A flush takes priority over a stall, so a cycle with both counts only as a flush.
  assign stall_ev_s = stall_i & valid_r & ~flush_i;
  assign flush_ev_s = flush_i & (valid_r | skid_valid_s);

  // Saturating stall/flush event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_ev_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_ev_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  if (SKID != 0) begin : g_skid
    localparam logic [1:0] ST_EMPTY     = 2'd0;
    localparam logic [1:0] ST_LOADED    = 2'd1;
    localparam logic [1:0] ST_FULL_SKID = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              ready_r;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;

    assign ready_s      = ready_r;
    assign skid_valid_s = (state_r == ST_FULL_SKID);
    assign in_xfer_s    = valid_i & ready_r;
    assign out_xfer_s   = valid_r & ready_i & ~stall_i;

    // Occupancy FSM next state; a stall only blocks the output side, so a
    // beat offered while LOADED and stalled lands in the skid entry.
    always_comb begin
      state_nxt_s = state_r;
      if (flush_i) begin
        state_nxt_s = ST_EMPTY;
      end else begin
        case (state_r)
          ST_EMPTY: begin
            if (in_xfer_s) begin
              state_nxt_s = ST_LOADED;
            end else begin
              state_nxt_s = ST_EMPTY;
            end
          end
          ST_LOADED: begin
            if (out_xfer_s && !in_xfer_s) begin
              state_nxt_s = ST_EMPTY;
            end else if (!out_xfer_s && in_xfer_s) begin
              state_nxt_s = ST_FULL_SKID;
            end else begin
              state_nxt_s = ST_LOADED;
            end
          end
          ST_FULL_SKID: begin
            if (out_xfer_s) begin
              state_nxt_s = ST_LOADED;
            end else begin
              state_nxt_s = ST_FULL_SKID;
            end
          end
          default: begin
            state_nxt_s = ST_EMPTY;
          end
        endcase
      end
    end

    // State, registered ready and main/skid data movement.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r     <= ST_EMPTY;
        ready_r     <= 1'b0;
        valid_r     <= 1'b0;
        ctrl_r      <= {CTRL_W{1'b0}};
        data_r      <= {DATA_W{1'b0}};
        skid_ctrl_r <= {CTRL_W{1'b0}};
        skid_data_r <= {DATA_W{1'b0}};
      end else begin
        state_r <= state_nxt_s;
        ready_r <= (state_nxt_s != ST_FULL_SKID);
        if (flush_i) begin
          // Bubble: all-zero control keeps RegWrite/MemWrite inactive.
          valid_r     <= 1'b0;
          ctrl_r      <= {CTRL_W{1'b0}};
          data_r      <= {DATA_W{1'b0}};
          skid_ctrl_r <= {CTRL_W{1'b0}};
          skid_data_r <= {DATA_W{1'b0}};
        end else begin
          case (state_r)
            ST_EMPTY: begin
              if (in_xfer_s) begin
                valid_r <= 1'b1;
                ctrl_r  <= ctrl_i;
                data_r  <= data_i;
              end
            end
            ST_LOADED: begin
              if (in_xfer_s && out_xfer_s) begin
                ctrl_r <= ctrl_i;
                data_r <= data_i;
              end else if (out_xfer_s) begin
                valid_r <= 1'b0;
              end else if (in_xfer_s) begin
                skid_ctrl_r <= ctrl_i;
                skid_data_r <= data_i;
              end
            end
            ST_FULL_SKID: begin
              if (out_xfer_s) begin
                ctrl_r <= skid_ctrl_r;
                data_r <= skid_data_r;
              end
            end
            default: begin
              valid_r <= 1'b0;
            end
          endcase
        end
      end
    end
  end else begin : g_noskid
    // Without a skid entry the stage can only accept when its single slot
    // is free or draining this cycle, so ready is combinational.
    assign ready_s      = ~rst & ~stall_i & (~valid_r | ready_i);
    assign skid_valid_s = 1'b0;

    // Single main register: flush clears, stall holds, otherwise load on ready.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        ctrl_r  <= {CTRL_W{1'b0}};
        data_r  <= {DATA_W{1'b0}};
      end else if (flush_i) begin
        valid_r <= 1'b0;
        ctrl_r  <= {CTRL_W{1'b0}};
        data_r  <= {DATA_W{1'b0}};
      end else if (ready_s) begin
        valid_r <= valid_i;
        ctrl_r  <= ctrl_i;
        data_r  <= data_i;
      end
    end
  end

  assign ready_o   = ready_s;
  assign valid_o   = valid_r;
  assign ctrl_o    = ctrl_r;
  assign data_o    = data_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, no-skid, 2-bit counters)
// share one stimulus stream; a queue-based reference model predicts outputs.
module tb_pipe_stage_reg;

  logic         clk;
  logic         rst;
  logic         valid_i;
  logic [7:0]   ctrl_i;
  logic [127:0] data_i;
  logic         stall_i;
  logic         flush_i;
  logic         ready_i;

  logic r1, v1, r0, v0, rc, vc;
  logic [7:0]   c1, c0, cc;
  logic [127:0] d1, d0, dc;
  logic [15:0]  sc1, fc1, sc0, fc0;
  logic [1:0]   scc, fcc;

  int errors = 0;
  int checks = 0;

  // Reference model state: the skid stage is an ordered queue of at most two beats.
  logic [7:0]   q_ctrl[$];
  logic [127:0] q_data[$];
  bit           m1_ready;
  int           m1_sn, m1_fn;
  bit           m0_valid;
  logic [7:0]   m0_ctrl;
  logic [127:0] m0_data;
  int           m0_sn, m0_fn;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(r1), .ctrl_i(ctrl_i), .data_i(data_i),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(v1), .ready_i(ready_i), .ctrl_o(c1),
    .data_o(d1), .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(r0), .ctrl_i(ctrl_i), .data_i(data_i),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(v0), .ready_i(ready_i), .ctrl_o(c0),
    .data_o(d0), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .SKID(1), .CNT_W(2)) u_dutc (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(rc), .ctrl_i(ctrl_i), .data_i(data_i),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(vc), .ready_i(ready_i), .ctrl_o(cc),
    .data_o(dc), .stall_cnt(scc), .flush_cnt(fcc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  // Advance the reference model by one clock edge using the inputs applied at that edge.
  task automatic model_edge();
    bit in1, out1, r0c;
    if (rst) begin
      q_ctrl.delete(); q_data.delete();
      m1_ready = 1'b0; m1_sn = 0; m1_fn = 0;
      m0_valid = 1'b0; m0_ctrl = 8'h00; m0_data = 128'h0; m0_sn = 0; m0_fn = 0;
    end else begin
      r0c = !stall_i && (!m0_valid || ready_i);
      if (flush_i) begin
        if (q_ctrl.size() > 0) m1_fn++;
        q_ctrl.delete(); q_data.delete();
        m1_ready = 1'b1;
      end else begin
        if (stall_i && q_ctrl.size() > 0) m1_sn++;
        out1 = (q_ctrl.size() > 0) && ready_i && !stall_i;
        in1  = valid_i && m1_ready;
        if (out1) begin
          void'(q_ctrl.pop_front());
          void'(q_data.pop_front());
        end
        if (in1) begin
          q_ctrl.push_back(ctrl_i);
          q_data.push_back(data_i);
        end
        m1_ready = (q_ctrl.size() < 2);
      end
      if (flush_i) begin
        if (m0_valid) m0_fn++;
        m0_valid = 1'b0;
      end else begin
        if (stall_i && m0_valid) m0_sn++;
        if (r0c) begin
          m0_valid = valid_i; m0_ctrl = ctrl_i; m0_data = data_i;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    valid_i = 1'b0; ready_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    ctrl_i = 8'h00; data_i = 128'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; ctrl_i = 8'hFF; data_i = {128{1'b1}};
    stall_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    tick(); tick(); #2;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b want 0", v1); end
    checks++; if (c1 !== 8'h00) begin errors++; $display("FAIL reset_ctrl1: got %h want 00", c1); end
    checks++; if (d1 !== 128'h0) begin errors++; $display("FAIL reset_data1: got %h want 0", d1); end
    checks++; if (sc1 !== 16'd0 || fc1 !== 16'd0) begin errors++; $display("FAIL reset_cnt1: got %0d/%0d want 0/0", sc1, fc1); end
    checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", r1); end
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", r0); end
    checks++; if (v0 !== 1'b0 || c0 !== 8'h00) begin errors++; $display("FAIL reset_out0: got %b/%h want 0/00", v0, c0); end
    rst = 1'b0; valid_i = 1'b0;
    #1;
    checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL release_ready1: got %b want 0", r1); end
    checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL release_ready0: got %b want 1", r0); end
    tick(); #2;
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL post_reset_ready1: got %b want 1", r1); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL post_reset_valid1: got %b want 0", v1); end
  endtask

  task automatic test_stream();
    logic [127:0] dv;
    do_reset();
    ready_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      valid_i = 1'b1; ctrl_i = 8'(k);
      dv = {$urandom(), $urandom(), $urandom(), $urandom()};
      data_i = dv;
      tick(); #2;
      checks++; if (v1 !== 1'b1 || c1 !== 8'(k) || d1 !== dv) begin errors++; $display("FAIL stream1_beat%0d: got %b/%h want 1/%h", k, v1, c1, 8'(k)); end
      checks++; if (v0 !== 1'b1 || c0 !== 8'(k) || d0 !== dv) begin errors++; $display("FAIL stream0_beat%0d: got %b/%h want 1/%h", k, v0, c0, 8'(k)); end
    end
    valid_i = 1'b0;
    tick(); #2;
    checks++; if (v1 !== 1'b0 || v0 !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b/%b want 0/0", v1, v0); end
  endtask

  task automatic test_skid();
    do_reset();
    ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 8'hA1;
    tick(); #2;
    checks++; if (v1 !== 1'b1 || c1 !== 8'hA1 || r1 !== 1'b1) begin errors++; $display("FAIL skid_a_loaded: got v%b c%h r%b want v1 cA1 r1", v1, c1, r1); end
    ctrl_i = 8'hB2;
    tick(); #2;
    checks++; if (c1 !== 8'hA1 || r1 !== 1'b0 || v1 !== 1'b1) begin errors++; $display("FAIL skid_b_in_skid: got v%b c%h r%b want v1 cA1 r0", v1, c1, r1); end
    valid_i = 1'b0; ready_i = 1'b1;
    tick(); #2;
    checks++; if (c1 !== 8'hB2 || v1 !== 1'b1 || r1 !== 1'b1) begin errors++; $display("FAIL skid_b_out: got v%b c%h r%b want v1 cB2 r1", v1, c1, r1); end
    tick(); #2;
    checks++; if (v1 !== 1'b0 || r1 !== 1'b1) begin errors++; $display("FAIL skid_empty: got v%b r%b want v0 r1", v1, r1); end
  endtask

  task automatic test_stall();
    logic [127:0] dv;
    do_reset();
    dv = {$urandom(), $urandom(), $urandom(), $urandom()};
    valid_i = 1'b1; ctrl_i = 8'h5C; data_i = dv; ready_i = 1'b1;
    tick();
    valid_i = 1'b0; stall_i = 1'b1;
    #1;
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL stall_ready0: got %b want 0", r0); end
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      checks++; if (v1 !== 1'b1 || c1 !== 8'h5C || d1 !== dv) begin errors++; $display("FAIL stall_hold1_%0d: got v%b c%h want v1 c5C", i, v1, c1); end
      checks++; if (v0 !== 1'b1 || c0 !== 8'h5C || d0 !== dv) begin errors++; $display("FAIL stall_hold0_%0d: got v%b c%h want v1 c5C", i, v0, c0); end
    end
    checks++; if (sc1 !== 16'd5) begin errors++; $display("FAIL stall_cnt1: got %0d want 5", sc1); end
    checks++; if (sc0 !== 16'd5) begin errors++; $display("FAIL stall_cnt0: got %0d want 5", sc0); end
    checks++; if (scc !== 2'd3) begin errors++; $display("FAIL stall_cnt_sat5: got %0d want 3", scc); end
    tick(); #2;
    checks++; if (sc1 !== 16'd6) begin errors++; $display("FAIL stall_cnt1_6: got %0d want 6", sc1); end
    checks++; if (scc !== 2'd3) begin errors++; $display("FAIL stall_cnt_sat6: got %0d want 3", scc); end
    stall_i = 1'b0;
    tick(); #2;
    checks++; if (v1 !== 1'b0 || v0 !== 1'b0 || sc1 !== 16'd6) begin errors++; $display("FAIL stall_release: got v%b v%b sc%0d want 0 0 6", v1, v0, sc1); end
  endtask

  task automatic test_flush();
    do_reset();
    ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 8'hA1; data_i = 128'h1;
    tick();
    ctrl_i = 8'hB2; data_i = 128'h2;
    tick();
    valid_i = 1'b0; stall_i = 1'b1;
    tick(); #2;
    checks++; if (sc1 !== 16'd1 || sc0 !== 16'd1 || r1 !== 1'b0) begin errors++; $display("FAIL flush_pre: got sc%0d sc%0d r%b want 1 1 0", sc1, sc0, r1); end
    flush_i = 1'b1; valid_i = 1'b1; ctrl_i = 8'hEE; data_i = 128'hEE;
    tick(); #2;
    checks++; if (v1 !== 1'b0 || c1 !== 8'h00 || d1 !== 128'h0) begin errors++; $display("FAIL flush_bubble1: got v%b c%h want v0 c00", v1, c1); end
    checks++; if (fc1 !== 16'd1 || sc1 !== 16'd1) begin errors++; $display("FAIL flush_cnt1: got f%0d s%0d want f1 s1", fc1, sc1); end
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL flush_ready1: got %b want 1", r1); end
    checks++; if (v0 !== 1'b0 || c0 !== 8'h00 || fc0 !== 16'd1 || sc0 !== 16'd1) begin errors++; $display("FAIL flush_skid0: got v%b c%h f%0d s%0d want 0 00 1 1", v0, c0, fc0, sc0); end
    checks++; if (fcc !== 2'd1) begin errors++; $display("FAIL flush_cntc: got %0d want 1", fcc); end
    flush_i = 1'b0; stall_i = 1'b0; ready_i = 1'b1; ctrl_i = 8'hC3; data_i = 128'h3;
    tick(); #2;
    checks++; if (v1 !== 1'b1 || c1 !== 8'hC3 || fc1 !== 16'd1) begin errors++; $display("FAIL flush_reload1: got v%b c%h f%0d want v1 cC3 f1", v1, c1, fc1); end
    checks++; if (v0 !== 1'b1 || c0 !== 8'hC3) begin errors++; $display("FAIL flush_reload0: got v%b c%h want v1 cC3", v0, c0); end
    valid_i = 1'b0;
  endtask

  task automatic test_comb_ready();
    do_reset();
    ready_i = 1'b0; valid_i = 1'b1; ctrl_i = 8'h77;
    tick();
    valid_i = 1'b0;
    #1;
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL comb_ready_full: got %b want 0", r0); end
    ready_i = 1'b1; #1;
    checks++; if (r0 !== 1'b1) begin errors++; $display("FAIL comb_ready_drain: got %b want 1", r0); end
    stall_i = 1'b1; #1;
    checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL comb_ready_stall: got %b want 0", r0); end
    stall_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit exp_r0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(99) == 0);
      valid_i = ($urandom_range(9) < 7);
      ready_i = ($urandom_range(9) < 6);
      stall_i = ($urandom_range(99) < 15);
      flush_i = ($urandom_range(99) < 5);
      ctrl_i  = 8'($urandom());
      data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
      #2;
      exp_r0 = !rst && !stall_i && (!m0_valid || ready_i);
      checks++; if (v1 !== (q_ctrl.size() > 0)) begin errors++; $display("FAIL rnd_valid1 @%0d: got %b want %b", n, v1, q_ctrl.size() > 0); end
      checks++; if (r1 !== m1_ready) begin errors++; $display("FAIL rnd_ready1 @%0d: got %b want %b", n, r1, m1_ready); end
      if (q_ctrl.size() > 0) begin
        checks++; if (c1 !== q_ctrl[0] || d1 !== q_data[0]) begin errors++; $display("FAIL rnd_data1 @%0d: got %h want %h", n, c1, q_ctrl[0]); end
      end
      checks++; if (sc1 !== 16'(sat(m1_sn, 65535)) || fc1 !== 16'(sat(m1_fn, 65535))) begin errors++; $display("FAIL rnd_cnt1 @%0d: got %0d/%0d want %0d/%0d", n, sc1, fc1, m1_sn, m1_fn); end
      checks++; if (scc !== 2'(sat(m1_sn, 3)) || fcc !== 2'(sat(m1_fn, 3))) begin errors++; $display("FAIL rnd_cntc @%0d: got %0d/%0d want %0d/%0d", n, scc, fcc, sat(m1_sn, 3), sat(m1_fn, 3)); end
      checks++; if (vc !== v1 || rc !== r1) begin errors++; $display("FAIL rnd_dutc @%0d: got v%b r%b want v%b r%b", n, vc, rc, v1, r1); end
      checks++; if (r0 !== exp_r0) begin errors++; $display("FAIL rnd_ready0 @%0d: got %b want %b", n, r0, exp_r0); end
      checks++; if (v0 !== m0_valid) begin errors++; $display("FAIL rnd_valid0 @%0d: got %b want %b", n, v0, m0_valid); end
      if (m0_valid) begin
        checks++; if (c0 !== m0_ctrl || d0 !== m0_data) begin errors++; $display("FAIL rnd_data0 @%0d: got %h want %h", n, c0, m0_ctrl); end
      end
      checks++; if (sc0 !== 16'(sat(m0_sn, 65535)) || fc0 !== 16'(sat(m0_fn, 65535))) begin errors++; $display("FAIL rnd_cnt0 @%0d: got %0d/%0d want %0d/%0d", n, sc0, fc0, m0_sn, m0_fn); end
      tick();
    end
    rst = 1'b0;
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_stream();
    test_skid();
    test_stall();
    test_flush();
    test_comb_ready();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
